// File: rtl/sevseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a small register file.
// Digit and hex-mask registers are double-buffered so a frame never shows a half-updated value.
module sevseg_scan_ctrl #(
  parameter int ON_CYCLES   = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int MAXC = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = (DEAD_CYCLES > 0) ? CW'(DEAD_CYCLES - 1) : '0;

  typedef enum logic {BLANK = 1'b0, ON = 1'b1} state_t;

  logic [3:0][7:0] dig, dig_nxt, sh_dig;
  logic [7:0]      ctrl, ctrl_nxt;
  logic [3:0]      sh_mask;
  logic            en;

  state_t          state, state_n;
  logic [1:0]      idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [7:0]      cur, pat, sseg_d;
  logic [3:0]      an_d;

  assign en = ctrl[0];

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    dig_nxt  = dig;
    ctrl_nxt = ctrl;
    if (wr_en) begin
      if (!wr_addr[2]) dig_nxt[wr_addr[1:0]] = wr_data;
      else if (wr_addr == 3'd4) ctrl_nxt = wr_data;
    end
  end

  // While disabled the shadows follow the value the front registers are about to take,
  // so a CTRL write that enables scanning already sees the mask written with it.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      dig     <= '0;
      ctrl    <= '0;
      sh_dig  <= '0;
      sh_mask <= '0;
    end else begin
      dig  <= dig_nxt;
      ctrl <= ctrl_nxt;
      if (!en) begin
        sh_dig  <= dig_nxt;
        sh_mask <= ctrl_nxt[7:4];
      end else if (frame_tick) begin
        sh_dig  <= dig;
        sh_mask <= ctrl[7:4];
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state <= BLANK;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    if (!en) begin
      state_n = BLANK;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        BLANK: begin
          if (DEAD_CYCLES == 0 || cnt == DEAD_LAST) begin
            state_n = ON;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == ON_LAST) begin
            state_n = (DEAD_CYCLES == 0) ? ON : BLANK;
            idx_n   = idx + 2'd1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    cur        = sh_dig[idx];
    pat        = sh_mask[idx] ? {cur[7], hex_glyph(cur[3:0])} : cur;
    frame_tick = en && (state == ON) && (idx == 2'd3) && (cnt == ON_LAST);
    if (en && state == ON) begin
      an_d   = ~(4'b0001 << idx);
      sseg_d = ~pat;
    end else begin
      an_d   = 4'hF;
      sseg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      an   <= 4'hF;
      sseg <= 8'hFF;
    end else begin
      an   <= an_d;
      sseg <= sseg_d;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Bench for sevseg_scan_ctrl: directed scenarios plus random register traffic,
// checked every cycle against a time-slot model of the scan.
module tb_sevseg_scan_ctrl;

  localparam int ON = 8;
  localparam int DEAD = 2;
  localparam int SLOT = ON + DEAD;
  localparam int PER = 4 * SLOT;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  sevseg_scan_ctrl #(.ON_CYCLES(ON), .DEAD_CYCLES(DEAD)) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .an(an),
    .sseg(sseg),
    .frame_tick(frame_tick)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: front/shadow registers and time since scanning was enabled.
  logic [7:0] m_dig [4];
  logic [7:0] m_ctrl;
  logic [7:0] m_sh [4];
  logic [3:0] m_mask;
  int         m_t;
  logic [3:0] m_an;
  logic [7:0] m_sseg;
  int         cyc = 0;
  int         last_ft = -1;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = '0;
      m_sh[i]  = '0;
    end
    m_ctrl  = '0;
    m_mask  = '0;
    m_t     = 0;
    m_an    = 4'hF;
    m_sseg  = 8'hFF;
    last_ft = -1;
  endtask

  // One clock cycle: check outputs, drive an optional write, advance the model.
  task automatic cycle(input logic we, input logic [2:0] wa, input logic [7:0] wd);
    logic       en, exp_ft, lit;
    int         slot;
    logic [7:0] pat, nd [4], nc;
    logic [3:0] one, an_n;
    logic [7:0] sseg_n;
    @(negedge clk_100MHz);
    en = m_ctrl[0];
    exp_ft = en && (m_t == PER - 1);
    check_eq("frame_tick", frame_tick, exp_ft);
    check_eq("an", an, m_an);
    check_eq("sseg", sseg, m_sseg);
    if (!en) last_ft = -1;
    if (frame_tick) begin
      if (last_ft >= 0) check_eq("frame_period", cyc - last_ft, PER);
      last_ft = cyc;
    end
    wr_en = we; wr_addr = wa; wr_data = wd;
    slot = m_t / SLOT;
    lit  = en && ((m_t % SLOT) >= DEAD);
    one  = 4'b0001;
    if (lit) begin
      pat    = m_mask[slot] ? {m_sh[slot][7], glyph_tab[m_sh[slot][3:0]]} : m_sh[slot];
      an_n   = ~(one << slot);
      sseg_n = ~pat;
    end else begin
      an_n   = 4'hF;
      sseg_n = 8'hFF;
    end
    for (int i = 0; i < 4; i++) nd[i] = m_dig[i];
    nc = m_ctrl;
    if (we && wa < 3'd4) nd[wa] = wd;
    if (we && wa == 3'd4) nc = wd;
    if (!en) begin
      for (int i = 0; i < 4; i++) m_sh[i] = nd[i];
      m_mask = nc[7:4];
    end else if (exp_ft) begin
      for (int i = 0; i < 4; i++) m_sh[i] = m_dig[i];
      m_mask = m_ctrl[7:4];
    end
    m_t = en ? (m_t + 1) % PER : 0;
    for (int i = 0; i < 4; i++) m_dig[i] = nd[i];
    m_ctrl = nc;
    @(posedge clk_100MHz);
    cyc++;
    m_an = an_n;
    m_sseg = sseg_n;
    #1 wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'h00);
  endtask

  // Called just after a rising edge; asserts reset between edges and checks the instant effect.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_sseg", sseg, 8'hFF);
    check_eq("rst_tick", frame_tick, 1'b0);
    model_reset();
    @(posedge clk_100MHz);
    cyc++;
    #2 reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk_100MHz);
    #2 reset = 1'b0;
    check_eq("init_an", an, 4'hF);
    check_eq("init_sseg", sseg, 8'hFF);

    // Hex digit 0 showing glyph 0.
    cycle(1'b1, 3'd0, 8'h00);
    cycle(1'b1, 3'd4, 8'hF1);
    idle(4);
    check_eq("hex0_an", an, 4'b1110);
    check_eq("hex0_sseg", sseg, 8'hC0);
    idle(60);

    // Raw pattern on digit 1.
    do_reset();
    cycle(1'b1, 3'd1, 8'hFF);
    cycle(1'b1, 3'd4, 8'h01);
    idle(13);
    check_eq("raw1_an", an, 4'b1101);
    check_eq("raw1_sseg", sseg, 8'h00);
    idle(50);

    // Mid-frame digit change only appears after the frame boundary.
    do_reset();
    cycle(1'b1, 3'd2, 8'h08);
    cycle(1'b1, 3'd4, 8'hF1);
    idle(24);
    check_eq("old_glyph", sseg, 8'h80);
    cycle(1'b1, 3'd2, 8'h0A);
    idle(5);
    check_eq("still_old", sseg, 8'h80);
    idle(35);
    check_eq("new_an", an, 4'b1011);
    check_eq("new_glyph", sseg, 8'h88);

    // Disable mid-ON blanks on the following cycle.
    cycle(1'b1, 3'd4, 8'h00);
    idle(1);
    check_eq("dis_an", an, 4'hF);
    check_eq("dis_sseg", sseg, 8'hFF);
    idle(5);

    // Reset in the middle of a lit slot.
    cycle(1'b1, 3'd3, 8'h5A);
    cycle(1'b1, 3'd4, 8'h81);
    idle(34);
    check_eq("pre_rst_an", an, 4'b0111);
    do_reset();
    idle(5);

    // Random register traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      logic [2:0] a;
      logic [7:0] d;
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      if (a == 3'd4) d[0] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle($urandom_range(0, 11) == 0, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
